// File: rtl/control_sequencer.sv
// Fetch/decode/execute control sequencer.
// Outputs are registered and are a function of state and IR only.
// Define SEQ_MULDIV_EN to enable the mul (5'h0E) and div (5'h0F) opcodes and the T6 step.
module control_sequencer (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Run,
  input  logic        Mem_Rdy,
  input  logic [31:0] IR,
  output logic        PC_Out,
  output logic        MDR_Out,
  output logic        ZLO_Out,
  output logic        ZHI_Out,
  output logic        PC_In,
  output logic        MDR_In,
  output logic        MAR_In,
  output logic        IR_In,
  output logic        Y_In,
  output logic        ZLO_In,
  output logic        ZHI_In,
  output logic        LO_In,
  output logic        HI_In,
  output logic        IncPC,
  output logic        Read,
  output logic        R_Out_En,
  output logic        R_In_En,
  output logic [3:0]  R_Out_Sel,
  output logic [3:0]  R_In_Sel,
  output logic [4:0]  CONTROL,
  output logic        Done,
  output logic        Illegal
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
    T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, HALT = 4'd8
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [4:0]  opcode;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic        muldiv_op;
  logic        legal_op;
  logic [3:0]  out_sel_q;
  logic        unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

`ifdef SEQ_MULDIV_EN
  assign muldiv_op = (opcode == 5'h0E) || (opcode == 5'h0F);
`else
  assign muldiv_op = 1'b0;
  assign ZHI_Out   = 1'b0;
  assign ZHI_In    = 1'b0;
  assign LO_In     = 1'b0;
  assign HI_In     = 1'b0;
`endif
  assign legal_op = (opcode <= 5'h0B) || muldiv_op;

  // IR only becomes valid in T3, so the T3 register select is decoded from it directly.
  assign R_Out_Sel = (state == T3) ? (muldiv_op ? ra : rb) : out_sel_q;

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Run) next_state = T0; else next_state = IDLE;
      T0:      next_state = T1;
      T1:      if (Mem_Rdy) next_state = T2; else next_state = T1;
      T2:      next_state = T3;
      T3:      if (legal_op) next_state = T4; else next_state = HALT;
      T4:      next_state = T5;
      T5: begin
        if (muldiv_op)  next_state = T6;
        else if (Run)   next_state = T0;
        else            next_state = IDLE;
      end
      T6:      if (Run) next_state = T0; else next_state = IDLE;
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  // State register and registered outputs for the state being entered.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state     <= IDLE;
      PC_Out    <= 1'b0;
      MDR_Out   <= 1'b0;
      ZLO_Out   <= 1'b0;
      PC_In     <= 1'b0;
      MDR_In    <= 1'b0;
      MAR_In    <= 1'b0;
      IR_In     <= 1'b0;
      Y_In      <= 1'b0;
      ZLO_In    <= 1'b0;
      IncPC     <= 1'b0;
      Read      <= 1'b0;
      R_Out_En  <= 1'b0;
      R_In_En   <= 1'b0;
      out_sel_q <= 4'd0;
      R_In_Sel  <= 4'd0;
      CONTROL   <= 5'd0;
      Done      <= 1'b0;
      Illegal   <= 1'b0;
`ifdef SEQ_MULDIV_EN
      ZHI_Out   <= 1'b0;
      ZHI_In    <= 1'b0;
      LO_In     <= 1'b0;
      HI_In     <= 1'b0;
`endif
    end else begin
      state     <= next_state;
      PC_Out    <= 1'b0;
      MDR_Out   <= 1'b0;
      ZLO_Out   <= 1'b0;
      PC_In     <= 1'b0;
      MDR_In    <= 1'b0;
      MAR_In    <= 1'b0;
      IR_In     <= 1'b0;
      Y_In      <= 1'b0;
      ZLO_In    <= 1'b0;
      IncPC     <= 1'b0;
      Read      <= 1'b0;
      R_Out_En  <= 1'b0;
      R_In_En   <= 1'b0;
      out_sel_q <= 4'd0;
      R_In_Sel  <= 4'd0;
      Done      <= 1'b0;
`ifdef SEQ_MULDIV_EN
      ZHI_Out   <= 1'b0;
      ZHI_In    <= 1'b0;
      LO_In     <= 1'b0;
      HI_In     <= 1'b0;
`endif
      case (next_state)
        T0: begin
          PC_Out <= 1'b1;
          MAR_In <= 1'b1;
          IncPC  <= 1'b1;
          ZLO_In <= 1'b1;
        end
        T1: begin
          ZLO_Out <= 1'b1;
          PC_In   <= (state != T1);
          Read    <= 1'b1;
          MDR_In  <= 1'b1;
        end
        T2: begin
          MDR_Out <= 1'b1;
          IR_In   <= 1'b1;
        end
        T3: begin
          R_Out_En <= 1'b1;
          Y_In     <= 1'b1;
        end
        T4: begin
          R_Out_En  <= 1'b1;
          out_sel_q <= muldiv_op ? rb : rc;
          CONTROL   <= opcode;
          ZLO_In    <= 1'b1;
`ifdef SEQ_MULDIV_EN
          ZHI_In    <= muldiv_op;
`endif
        end
        T5: begin
          ZLO_Out <= 1'b1;
`ifdef SEQ_MULDIV_EN
          LO_In   <= muldiv_op;
`endif
          if (!muldiv_op) begin
            R_In_En  <= 1'b1;
            R_In_Sel <= ra;
            Done     <= 1'b1;
          end else begin
            R_In_En  <= 1'b0;
          end
        end
        T6: begin
`ifdef SEQ_MULDIV_EN
          ZHI_Out <= 1'b1;
          HI_In   <= 1'b1;
          Done    <= 1'b1;
`endif
        end
        HALT:    Illegal <= 1'b1;
        default: Illegal <= Illegal;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed + randomized bench for control_sequencer; expected outputs come from a
// per-step micro-operation model of the instruction cycle.
module tb_control_sequencer;

`ifdef SEQ_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  localparam logic [16:0] F_NONE    = 17'd0;
  localparam logic [16:0] F_PC_OUT  = 17'h10000;
  localparam logic [16:0] F_MDR_OUT = 17'h08000;
  localparam logic [16:0] F_ZLO_OUT = 17'h04000;
  localparam logic [16:0] F_ZHI_OUT = 17'h02000;
  localparam logic [16:0] F_PC_IN   = 17'h01000;
  localparam logic [16:0] F_MDR_IN  = 17'h00800;
  localparam logic [16:0] F_MAR_IN  = 17'h00400;
  localparam logic [16:0] F_IR_IN   = 17'h00200;
  localparam logic [16:0] F_Y_IN    = 17'h00100;
  localparam logic [16:0] F_ZLO_IN  = 17'h00080;
  localparam logic [16:0] F_ZHI_IN  = 17'h00040;
  localparam logic [16:0] F_LO_IN   = 17'h00020;
  localparam logic [16:0] F_HI_IN   = 17'h00010;
  localparam logic [16:0] F_INCPC   = 17'h00008;
  localparam logic [16:0] F_READ    = 17'h00004;
  localparam logic [16:0] F_ROUT_EN = 17'h00002;
  localparam logic [16:0] F_RIN_EN  = 17'h00001;

  logic        Clock = 1'b0;
  logic        Clear, Run, Mem_Rdy;
  logic [31:0] IR;
  logic PC_Out, MDR_Out, ZLO_Out, ZHI_Out, PC_In, MDR_In, MAR_In, IR_In, Y_In;
  logic ZLO_In, ZHI_In, LO_In, HI_In, IncPC, Read, R_Out_En, R_In_En, Done, Illegal;
  logic [3:0] R_Out_Sel, R_In_Sel;
  logic [4:0] CONTROL;
  logic [31:0] obs;

  int checks = 0, failures = 0, done_seen = 0, cyc = 0, last_done = 0;
  int go_cyc, d0, res;
  logic [4:0] ctrl;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .Mem_Rdy(Mem_Rdy), .IR(IR),
    .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out), .ZHI_Out(ZHI_Out),
    .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In), .IR_In(IR_In), .Y_In(Y_In),
    .ZLO_In(ZLO_In), .ZHI_In(ZHI_In), .LO_In(LO_In), .HI_In(HI_In),
    .IncPC(IncPC), .Read(Read), .R_Out_En(R_Out_En), .R_In_En(R_In_En),
    .R_Out_Sel(R_Out_Sel), .R_In_Sel(R_In_Sel), .CONTROL(CONTROL),
    .Done(Done), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  assign obs = {PC_Out, MDR_Out, ZLO_Out, ZHI_Out, PC_In, MDR_In, MAR_In, IR_In, Y_In,
                ZLO_In, ZHI_In, LO_In, HI_In, IncPC, Read, R_Out_En, R_In_En,
                R_Out_Sel, R_In_Sel, CONTROL, Done, Illegal};

  function automatic logic [31:0] w(input logic [16:0] f, input logic [3:0] os,
                                    input logic [3:0] is, input logic [4:0] c,
                                    input logic d, input logic il);
    return {f, os, is, c, d, il};
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit is_md(input logic [4:0] op);
    return MD && (op == 5'h0E || op == 5'h0F);
  endfunction

  function automatic bit is_legal(input logic [4:0] op);
    return (op <= 5'h0B) || is_md(op);
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance past the edge.
  task automatic step(input bit clr, input bit run, input bit rdy,
                      input logic [31:0] exp, input string tag);
    Clear = clr; Run = run; Mem_Rdy = rdy;
    @(negedge Clock);
    cyc++;
    checks++;
    if (Done === 1'b1) begin
      done_seen++;
      last_done = cyc;
    end
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic check_int(input int act, input int req, input string tag);
    checks++;
    assert (act === req) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, req);
    end
  endtask

  task automatic go();
    step(1'b1, 1'b1, rbit(), w(F_NONE, 4'd0, 4'd0, ctrl, 1'b0, 1'b0), "idle_go");
  endtask

  task automatic halt_seq(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b1, rbit(), w(F_NONE, 4'd0, 4'd0, ctrl, 1'b0, 1'b1), "halt_hold");
    step(1'b0, rbit(), rbit(), w(F_NONE, 4'd0, 4'd0, ctrl, 1'b0, 1'b1), "halt_clear");
    ctrl = 5'd0;
    step(1'b1, 1'b0, rbit(), w(F_NONE, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0), "post_halt_idle");
  endtask

  // Runs one instruction starting in T0. res: 0 completed, 1 reset mid-way, 2 halted.
  task automatic do_instr(input logic [31:0] ir, input int waits, input bit run_last,
                          input int abort, output int r);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic [31:0] e;
    bit md;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    md = is_md(op);
    IR = $urandom;
    step(1'b1, rbit(), rbit(),
         w(F_PC_OUT | F_MAR_IN | F_INCPC | F_ZLO_IN, 4'd0, 4'd0, ctrl, 1'b0, 1'b0), "t0");
    for (int i = 0; i <= waits; i++) begin
      e = w(F_ZLO_OUT | F_READ | F_MDR_IN | ((i == 0) ? F_PC_IN : F_NONE),
            4'd0, 4'd0, ctrl, 1'b0, 1'b0);
      if (abort == 1 && i == 1) begin
        step(1'b0, rbit(), rbit(), e, "abort_t1");
        ctrl = 5'd0;
        step(1'b1, 1'b0, rbit(), w(F_NONE, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0), "abort_t1_idle");
        r = 1;
        return;
      end
      step(1'b1, rbit(), (i == waits), e, "t1");
    end
    step(1'b1, rbit(), rbit(), w(F_MDR_OUT | F_IR_IN, 4'd0, 4'd0, ctrl, 1'b0, 1'b0), "t2");
    IR = ir;
    step(1'b1, rbit(), rbit(), w(F_ROUT_EN | F_Y_IN, md ? ra : rb, 4'd0, ctrl, 1'b0, 1'b0), "t3");
    if (!is_legal(op)) begin
      r = 2;
      return;
    end
    e = w(F_ROUT_EN | F_ZLO_IN | (md ? F_ZHI_IN : F_NONE), md ? rb : rc, 4'd0, op, 1'b0, 1'b0);
    if (abort == 2) begin
      step(1'b0, rbit(), rbit(), e, "abort_t4");
      ctrl = 5'd0;
      step(1'b1, 1'b0, rbit(), w(F_NONE, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0), "abort_t4_idle");
      r = 1;
      return;
    end
    step(1'b1, rbit(), rbit(), e, "t4");
    ctrl = op;
    if (md) begin
      step(1'b1, rbit(), rbit(), w(F_ZLO_OUT | F_LO_IN, 4'd0, 4'd0, ctrl, 1'b0, 1'b0), "t5_md");
      step(1'b1, run_last, rbit(), w(F_ZHI_OUT | F_HI_IN, 4'd0, 4'd0, ctrl, 1'b1, 1'b0), "t6_md");
    end else begin
      step(1'b1, run_last, rbit(), w(F_ZLO_OUT | F_RIN_EN, 4'd0, ra, ctrl, 1'b1, 1'b0), "t5");
    end
    r = 0;
  endtask

  initial begin
    Clear = 1'b0; Run = 1'b1; Mem_Rdy = 1'b0; IR = 32'd0; ctrl = 5'd0;
    @(posedge Clock);
    #1;
    // Reset with Run held high must stay idle until Clear is released.
    step(1'b0, 1'b1, 1'b1, w(F_NONE, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0), "reset");
    step(1'b0, 1'b1, 1'b1, w(F_NONE, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0), "reset_run");
    go();
    go_cyc = cyc;
    do_instr(32'h4A200000, 0, 1'b0, 0, res);
    check_int(last_done - go_cyc, 6, "latency_nowait");

    step(1'b1, 1'b0, rbit(), w(F_NONE, 4'd0, 4'd0, ctrl, 1'b0, 1'b0), "idle_hold");
    go();
    go_cyc = cyc;
    do_instr({5'h03, 4'd7, 4'd2, 4'd9, 15'd0}, 3, 1'b0, 0, res);
    check_int(last_done - go_cyc, 9, "latency_wait3");

    // Back-to-back: second instruction writes register 0.
    go();
    d0 = done_seen;
    do_instr({5'h0B, 4'd5, 4'd6, 4'd1, 15'h1234}, 0, 1'b1, 0, res);
    do_instr({5'h00, 4'd0, 4'd3, 4'd15, 15'h7FFF}, 1, 1'b0, 0, res);
    check_int(done_seen - d0, 2, "b2b_done_count");

    go();
    do_instr({5'h05, 4'd1, 4'd2, 4'd3, 15'd0}, 1, 1'b0, 2, res);
    check_int(res, 1, "abort_t4_res");
    go();
    do_instr({5'h06, 4'd1, 4'd2, 4'd3, 15'd0}, 3, 1'b0, 1, res);
    go();
    do_instr({5'h0E, 4'd8, 4'd9, 4'd10, 15'd0}, 0, 1'b0, 0, res);
    check_int(res, MD ? 0 : 2, "mul_outcome");
    if (res == 2) halt_seq(2);
    go();
    do_instr({5'h1F, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 1'b1, 0, res);
    check_int(res, 2, "illegal_outcome");
    halt_seq(10);

    go();
    for (int n = 0; n < 30; n++) begin
      logic [4:0] op;
      int sel, waits, abort;
      bit run_last;
      sel = $urandom_range(0, 9);
      if (sel < 6)      op = 5'($urandom_range(0, 11));
      else if (sel < 8) op = 5'($urandom_range(14, 15));
      else              op = 5'($urandom_range(12, 31));
      waits = $urandom_range(0, 3);
      run_last = rbit();
      abort = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      if (abort == 1 && waits == 0) waits = 1;
      do_instr({op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 15'($urandom)}, waits, run_last, abort, res);
      if (res == 2) begin
        halt_seq($urandom_range(1, 4));
        go();
      end else if (res == 1 || !run_last) begin
        go();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
